// File: rtl/instr_encoder_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader_pkg
//
// Shared definitions for the instruction loader and the core's immediate
// generator.
//   - Instruction format selectors (FMT_*), carried on a 3-bit fmt bus.
//   - RV32I major opcodes (OPC_*).
//   - Loader FSM state encoding.
//   - upper_uniform(): true when every bit of a value from position lsb up to
//     bit 31 holds the same level, meaning the value still fits once the
//     upper bits are dropped.
// No ports: this is a package.
// -----------------------------------------------------------------------------
package instr_encoder_loader_pkg;

    // Instruction format selectors. The codes 3'b110 and 3'b111 are illegal.
    localparam logic [2:0] FMT_I = 3'b000;
    localparam logic [2:0] FMT_S = 3'b001;
    localparam logic [2:0] FMT_B = 3'b010;
    localparam logic [2:0] FMT_U = 3'b011;
    localparam logic [2:0] FMT_J = 3'b100;
    localparam logic [2:0] FMT_R = 3'b101;

    // RV32I major opcodes, instr[6:0].
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Loader FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } ld_state_e;

    // Arithmetic right shift by lsb leaves either all zeros or all ones
    // exactly when bits [31:lsb] are uniform. Here, that means the signed
    // value is representable in an lsb+1 bit field.
    function automatic logic upper_uniform(input logic signed [31:0] value,
                                           input int unsigned        lsb);
        logic signed [31:0] shifted;
        shifted = value >>> lsb;
        return (shifted == '0) || (shifted == '1);
    endfunction

endpackage

// File: rtl/instr_encoder_loader_imm_pack.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader_imm_pack
//
// Combinational inverse of the immediate generator. It scatters a 32-bit
// immediate into the bit positions used by the selected RV32I format. It also
// reports whether the immediate can be encoded without loss.
//
// Ports
//   fmt      in   3   format selector (FMT_I..FMT_R; 110/111 are illegal)
//   opcode   in   7   instr[6:0]
//   rd       in   5   destination register
//   rs1      in   5   source register 1
//   rs2      in   5   source register 2
//   funct3   in   3   funct3 field
//   funct7   in   7   funct7 field, used only by R format
//   imm      in  32   full-width immediate
//   word     out 32   packed instruction
//   legal    out  1   immediate fits the format and the format code is valid
// -----------------------------------------------------------------------------
module instr_encoder_loader_imm_pack
    import instr_encoder_loader_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    logic signed [31:0] imm_s;

    assign imm_s = $signed(imm);

    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (fmt)
            FMT_I: begin
                word  = {imm[11:0], rs1, funct3, rd, opcode};
                legal = upper_uniform(imm_s, 11);
            end
            FMT_S: begin
                word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal = upper_uniform(imm_s, 11);
            end
            FMT_B: begin
                // Branch offsets are even, so imm[0] is not stored.
                word  = {imm[12], imm[10:5], rs2, rs1, funct3,
                         imm[4:1], imm[11], opcode};
                legal = upper_uniform(imm_s, 12) && !imm[0];
            end
            FMT_U: begin
                // The low 12 bits are implied zero and cannot be encoded.
                word  = {imm[31:12], rd, opcode};
                legal = (imm[11:0] == 12'd0);
            end
            FMT_J: begin
                word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                legal = upper_uniform(imm_s, 20) && !imm[0];
            end
            FMT_R: begin
                word  = {funct7, rs2, rs1, funct3, rd, opcode};
                legal = 1'b1;
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
//
// Boot/test loader front end. It accepts decoded instruction fields over a
// valid/ready handshake and packs them into RV32I words. Each legal word is
// written into instruction memory at consecutive word addresses, starting at
// the base address given with load_start. Bundles whose immediate cannot be
// encoded are dropped and flagged. The session stops accepting bundles
// after a legal write lands in the last word.
//
// Ports
//   clk         in   1         system clock
//   rst         in   1         synchronous active-high reset
//   load_start  in   1         pulse: (re)start a session at base_addr
//   load_stop   in   1         pulse: end the session
//   base_addr   in   ADDR_W    first word address, sampled on load_start
//   in_valid    in   1         field bundle valid
//   in_ready    out  1         bundle can be accepted this cycle
//   fmt         in   3         instruction format selector
//   opcode      in   7         instr[6:0]
//   rd/rs1/rs2  in   5 each    register fields
//   funct3      in   3         funct3 field
//   funct7      in   7         funct7 field (R format)
//   imm         in  32         immediate value
//   mem_we      out  1         imem write enable
//   mem_addr    out  ADDR_W    imem write address
//   mem_wdata   out 32         packed instruction
//   err_pulse   out  1         one-cycle pulse: bundle rejected
//   err_sticky  out  1         a bundle was rejected this session
//   loaded_cnt  out  ADDR_W+1  words written this session
//   full        out  1         last imem word has been written
// -----------------------------------------------------------------------------
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_stop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              err_pulse,
    output logic              err_sticky,
    output logic [ADDR_W:0]   loaded_cnt,
    output logic              full
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ld_state_e         state_q;
    ld_state_e         state_d;
    logic [ADDR_W-1:0] wr_ptr_q;

    logic [31:0]       word_p0;
    logic              legal_p0;
    logic              xfer_p0;
    logic              at_top_p0;

    // ---- Stage p0: handshake, pack and range check (combinational) ----------

    instr_encoder_loader_imm_pack u_imm_pack (
        .fmt    (fmt),
        .opcode (opcode),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .funct3 (funct3),
        .funct7 (funct7),
        .imm    (imm),
        .word   (word_p0),
        .legal  (legal_p0)
    );

    // A restart discards any bundle that arrives in the same cycle.
    assign xfer_p0   = in_valid && (state_q == LOAD) && !load_start;
    assign at_top_p0 = (wr_ptr_q == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (load_start) begin
                    state_d = LOAD;
                end else if (load_stop) begin
                    // A same-cycle transfer still completes in the datapath.
                    state_d = IDLE;
                end else if (xfer_p0 && legal_p0 && at_top_p0) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (load_start) begin
                    state_d = LOAD;
                end else if (load_stop) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---- Stage p1: registered memory write / error outputs ------------------

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            loaded_cnt <= '0;
            full       <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            err_pulse <= 1'b0;
            if (load_start) begin
                wr_ptr_q   <= base_addr;
                loaded_cnt <= '0;
                err_sticky <= 1'b0;
                full       <= 1'b0;
            end else if (xfer_p0) begin
                if (legal_p0) begin
                    mem_we     <= 1'b1;
                    mem_addr   <= wr_ptr_q;
                    mem_wdata  <= word_p0;
                    loaded_cnt <= loaded_cnt + (ADDR_W + 1)'(1);
                    // The pointer parks on the last word instead of wrapping.
                    if (at_top_p0) begin
                        full <= 1'b1;
                    end else begin
                        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                    end
                end else begin
                    // mem_addr/mem_wdata keep the last write; pointer holds.
                    err_pulse  <= 1'b1;
                    err_sticky <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder_loader
//
// Self-checking bench for instr_encoder_loader: reset state, a table of
// hand-encoded instructions, hand-written boundary sequences, then
// randomized traffic compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_instr_encoder_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_start;
    logic              load_stop;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              err_pulse;
    logic              err_sticky;
    logic [ADDR_W:0]   loaded_cnt;
    logic              full;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_stop  (load_stop),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fmt        (fmt),
        .opcode     (opcode),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .funct3     (funct3),
        .funct7     (funct7),
        .imm        (imm),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .loaded_cnt (loaded_cnt),
        .full       (full)
    );

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        fmt      = v.fmt;
        opcode   = v.op;
        rd       = v.rd;
        rs1      = v.rs1;
        rs2      = v.rs2;
        funct3   = v.f3;
        funct7   = v.f7;
        imm      = v.imm;
        in_valid = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " mem_we"},     mem_we,     0);
        check({tag, " mem_addr"},   mem_addr,   0);
        check({tag, " mem_wdata"},  mem_wdata,  0);
        check({tag, " err_pulse"},  err_pulse,  0);
        check({tag, " err_sticky"}, err_sticky, 0);
        check({tag, " loaded_cnt"}, loaded_cnt, 0);
        check({tag, " full"},       full,       0);
        check({tag, " in_ready"},   in_ready,   0);
    endtask

    // ---- Reference model: encodability from numeric ranges ------------------
    function automatic logic ref_legal(input logic [2:0] f, input logic [31:0] v);
        longint s;
        s = longint'($signed(v));
        case (f)
            3'd0, 3'd1: return (s >= -2048) && (s <= 2047);
            3'd2:       return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
            3'd3:       return (v % 4096) == 0;
            3'd4:       return (s >= -1048576) && (s <= 1048575) && (s % 2 == 0);
            3'd5:       return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic longint bits(input logic [31:0] v, input int hi, input int lo);
        longint u;
        u = longint'(v);
        return (u >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
    endfunction

    // ---- Reference model: word layout as field value times place weight ----
    function automatic logic [31:0] ref_word(input logic [2:0] f, input logic [6:0] op,
                                             input logic [4:0] d, input logic [4:0] s1,
                                             input logic [4:0] s2, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [31:0] v);
        longint w;
        longint regs;
        regs = (longint'(s2) << 20) + (longint'(s1) << 15) + (longint'(f3) << 12);
        case (f)
            3'd0: w = (bits(v, 11, 0) << 20) + (longint'(s1) << 15) + (longint'(f3) << 12)
                      + (longint'(d) << 7) + longint'(op);
            3'd1: w = (bits(v, 11, 5) << 25) + regs + (bits(v, 4, 0) << 7) + longint'(op);
            3'd2: w = (bits(v, 12, 12) << 31) + (bits(v, 10, 5) << 25) + regs
                      + (bits(v, 4, 1) << 8) + (bits(v, 11, 11) << 7) + longint'(op);
            3'd3: w = (bits(v, 31, 12) << 12) + (longint'(d) << 7) + longint'(op);
            3'd4: w = (bits(v, 20, 20) << 31) + (bits(v, 10, 1) << 21) + (bits(v, 11, 11) << 20)
                      + (bits(v, 19, 12) << 12) + (longint'(d) << 7) + longint'(op);
            default: w = (longint'(f7) << 25) + regs + (longint'(d) << 7) + longint'(op);
        endcase
        return w[31:0];
    endfunction

    function automatic logic [31:0] pick_imm();
        logic [31:0] edges[10];
        edges = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF, 32'd4094,
                  32'd4096, 32'hFFFFF000, 32'h000FFFFE, 32'h00100000, 32'hFFF00000};
        case ($urandom_range(0, 5))
            0:       return 32'($urandom);
            1:       return 32'($urandom_range(0, 8191)) - 32'd4096;
            2:       return 32'($urandom) & 32'hFFFFF000;
            3:       return (32'($urandom_range(0, 4194303)) - 32'd2097152) & 32'hFFFFFFFE;
            4:       return edges[$urandom_range(0, 9)];
            default: return 32'($urandom_range(0, 4095)) & 32'hFFFFFFFE;
        endcase
    endfunction

    initial begin
        logic [ADDR_W-1:0] exp_ptr;
        logic [ADDR_W-1:0] last_addr;
        int                exp_cnt;
        vec_t              good_i;
        vec_t              bad_i;

        // model state for the random phase
        logic              m_active;
        logic [ADDR_W-1:0] m_ptr;
        int                m_cnt;
        logic              m_sticky;
        logic              m_full;
        logic [ADDR_W-1:0] m_addr;
        logic [31:0]       m_wdata;
        logic              e_we;
        logic              e_err;

        vecs[0]  = '{3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,        1'b1, 32'h00500093};
        vecs[1]  = '{3'd1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,        1'b1, 32'h0020A423};
        vecs[2]  = '{3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b1, 32'hFE000EE3};
        vecs[3]  = '{3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,     1'b1, 32'h001000EF};
        vecs[4]  = '{3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1, 32'h123452B7};
        vecs[5]  = '{3'd5, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEADBEEF, 1'b1, 32'h002081B3};
        vecs[6]  = '{3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,     1'b0, 32'h0};
        vecs[7]  = '{3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,        1'b0, 32'h0};
        vecs[8]  = '{3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 1'b0, 32'h0};
        vecs[9]  = '{3'd6, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,        1'b0, 32'h0};
        vecs[10] = '{3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,        1'b0, 32'h0};
        vecs[11] = '{3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1,        1'b0, 32'h0};
        vecs[12] = '{3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 1'b1, 32'h80000093};
        vecs[13] = '{3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047,     1'b1, 32'h7FF00093};
        good_i = vecs[0];
        bad_i  = vecs[6];

        rst = 1'b1; load_start = 1'b0; load_stop = 1'b0; base_addr = '0;
        in_valid = 1'b0; fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
        funct3 = '0; funct7 = '0; imm = '0;

        // ---- reset state ----
        tick(); tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        apply(good_i);
        tick();
        check("idle no write", mem_we, 0);
        in_valid = 1'b0;

        // ---- table: back-to-back legal and illegal bundles from 0x10 ----
        load_start = 1'b1; base_addr = 8'h10;
        tick();
        load_start = 1'b0;
        check("start in_ready", in_ready, 1);
        check("start cnt", loaded_cnt, 0);
        exp_ptr = 8'h10; exp_cnt = 0; last_addr = '0;
        for (int i = 0; i < 14; i++) begin
            apply(vecs[i]);
            tick();
            if (vecs[i].legal) begin
                check($sformatf("vec%0d mem_we", i), mem_we, 1);
                check($sformatf("vec%0d mem_addr", i), mem_addr, exp_ptr);
                check($sformatf("vec%0d mem_wdata", i), mem_wdata, vecs[i].word);
                check($sformatf("vec%0d err_pulse", i), err_pulse, 0);
                last_addr = exp_ptr;
                exp_ptr++;
                exp_cnt++;
            end else begin
                check($sformatf("vec%0d mem_we", i), mem_we, 0);
                check($sformatf("vec%0d err_pulse", i), err_pulse, 1);
                check($sformatf("vec%0d err_sticky", i), err_sticky, 1);
                check($sformatf("vec%0d mem_addr", i), mem_addr, last_addr);
            end
            check($sformatf("vec%0d loaded_cnt", i), loaded_cnt, exp_cnt);
        end
        in_valid = 1'b0;
        tick();
        check("table idle mem_we", mem_we, 0);
        check("table idle err_pulse", err_pulse, 0);
        check("table sticky held", err_sticky, 1);

        // ---- top of memory: 254, 255, then full ----
        load_start = 1'b1; base_addr = 8'(DEPTH - 2);
        tick();
        load_start = 1'b0;
        check("restart clears sticky", err_sticky, 0);
        apply(good_i);
        tick();
        check("top w0 we", mem_we, 1);
        check("top w0 addr", mem_addr, DEPTH - 2);
        check("top w0 full", full, 0);
        tick();
        check("top w1 we", mem_we, 1);
        check("top w1 addr", mem_addr, DEPTH - 1);
        check("top full", full, 1);
        check("top in_ready", in_ready, 0);
        check("top cnt", loaded_cnt, 2);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("full no write", mem_we, 0);
            check("full cnt held", loaded_cnt, 2);
            check("full in_ready", in_ready, 0);
        end
        in_valid = 1'b0; load_stop = 1'b1;
        tick();
        load_stop = 1'b0;
        check("stop keeps full", full, 1);
        check("stop in_ready", in_ready, 0);
        load_start = 1'b1; base_addr = 8'h40;
        tick();
        load_start = 1'b0;
        check("restart clears full", full, 0);
        check("restart in_ready", in_ready, 1);
        check("restart cnt", loaded_cnt, 0);

        // ---- illegal bundle at the last address does not fill ----
        load_start = 1'b1; base_addr = 8'(DEPTH - 1);
        tick();
        load_start = 1'b0;
        apply(bad_i);
        tick();
        check("top bad err", err_pulse, 1);
        check("top bad full", full, 0);
        in_valid = 1'b0;
        tick();
        check("top bad in_ready", in_ready, 1);
        apply(good_i);
        tick();
        check("top good addr", mem_addr, DEPTH - 1);
        check("top good full", full, 1);
        in_valid = 1'b0;

        // ---- load_start with a same-cycle bundle while loading ----
        load_start = 1'b1; base_addr = 8'h20;
        tick();
        load_start = 1'b0;
        apply(good_i);
        tick();
        check("pre-restart addr", mem_addr, 8'h20);
        load_start = 1'b1; base_addr = 8'h30;
        tick();
        load_start = 1'b0;
        check("restart drops we", mem_we, 0);
        check("restart drops cnt", loaded_cnt, 0);
        tick();
        check("after restart addr", mem_addr, 8'h30);
        check("after restart cnt", loaded_cnt, 1);

        // ---- reset in the cycle after a transfer ----
        tick();
        check("pre-reset we", mem_we, 1);
        rst = 1'b1;
        tick();
        check_reset_outputs("midreset");
        rst = 1'b0; in_valid = 1'b0;
        tick();
        check("post-reset idle ready", in_ready, 0);
        check("post-reset no write", mem_we, 0);

        // ---- randomized traffic against the model ----
        m_active = 1'b0; m_ptr = '0; m_cnt = 0; m_sticky = 1'b0; m_full = 1'b0;
        m_addr = '0; m_wdata = '0;
        for (int n = 0; n < 3000; n++) begin
            load_start = ($urandom_range(0, 99) < 3);
            load_stop  = ($urandom_range(0, 99) < 3);
            in_valid   = ($urandom_range(0, 99) < 75);
            base_addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(DEPTH - 6, DEPTH - 1))
                                                      : 8'($urandom);
            fmt    = 3'($urandom_range(0, 7));
            opcode = 7'($urandom);
            rd     = 5'($urandom);
            rs1    = 5'($urandom);
            rs2    = 5'($urandom);
            funct3 = 3'($urandom);
            funct7 = 7'($urandom);
            imm    = pick_imm();
            #1;
            check("rand in_ready", in_ready, m_active);
            e_we = 1'b0; e_err = 1'b0;
            if (load_start) begin
                m_active = 1'b1; m_ptr = base_addr; m_cnt = 0;
                m_sticky = 1'b0; m_full = 1'b0;
            end else begin
                if (in_valid && m_active) begin
                    if (ref_legal(fmt, imm)) begin
                        e_we    = 1'b1;
                        m_addr  = m_ptr;
                        m_wdata = ref_word(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
                        m_cnt++;
                        if (int'(m_ptr) == DEPTH - 1) begin
                            m_full = 1'b1; m_active = 1'b0;
                        end else begin
                            m_ptr++;
                        end
                    end else begin
                        e_err = 1'b1; m_sticky = 1'b1;
                    end
                end
                if (load_stop) m_active = 1'b0;
            end
            tick();
            check("rand mem_we", mem_we, e_we);
            check("rand err_pulse", err_pulse, e_err);
            check("rand mem_addr", mem_addr, m_addr);
            check("rand mem_wdata", mem_wdata, m_wdata);
            check("rand loaded_cnt", loaded_cnt, m_cnt);
            check("rand err_sticky", err_sticky, m_sticky);
            check("rand full", full, m_full);
        end
        load_start = 1'b0; load_stop = 1'b0; in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the core's immediate generator. Accepts decoded instruction fields plus a 32-bit immediate over a valid/ready handshake.
- Range-checks the immediate for the selected format, packs it into a 32-bit RV32I instruction word, and writes the word into instruction memory at consecutive word addresses.
- Used by the boot/test loader path to fill imem before the single-cycle core runs.

Parameters:
- ADDR_W, 8, imem word-address width
- DEPTH, 256, number of imem words; the last writable address is DEPTH-1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load_start  in  1  one-cycle pulse: begin loading at base_addr
- load_stop  in  1  one-cycle pulse: end the load session
- base_addr  in  ADDR_W  first word address, sampled on load_start
- in_valid  in  1  field bundle valid
- in_ready  out  1  block can accept a bundle this cycle
- fmt  in  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 R; 110 and 111 are illegal
- opcode  in  7  instr[6:0]
- rd, rs1, rs2  in  5 each  register fields
- funct3  in  3  funct3 field
- funct7  in  7  funct7 field, R format only
- imm  in  32  full-width immediate value
- mem_we  out  1  imem write enable
- mem_addr  out  ADDR_W  imem write address
- mem_wdata  out  32  packed instruction
- err_pulse  out  1  one-cycle pulse: bundle rejected
- err_sticky  out  1  set on any rejection; cleared by rst or load_start
- loaded_cnt  out  ADDR_W+1  words written this session
- full  out  1  address space exhausted

Behaviour:
- Reset values:
  - state = IDLE.
  - in_ready, mem_we, err_pulse, err_sticky, full = 0.
  - mem_addr, mem_wdata, loaded_cnt = 0.
- FSM states: IDLE, LOAD, FULL.
- IDLE:
  - in_ready = 0.
  - load_start -> LOAD. Write pointer = base_addr; loaded_cnt, err_sticky and full are cleared.
- LOAD:
  - in_ready = 1.
  - A transfer happens when in_valid and in_ready are both 1 on a rising edge.
  - load_stop -> IDLE. A transfer in the same cycle is still completed.
  - load_start in LOAD restarts the session as in IDLE. It takes priority over load_stop and over a same-cycle transfer, which is discarded.
- Packing, for an accepted bundle (imm bits named imm[n]):
  - I: imm[11:0], rs1, funct3, rd, opcode
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode
  - U: imm[31:12], rd, opcode
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode
  - R: funct7, rs2, rs1, funct3, rd, opcode
- Legality checks; any failure rejects the bundle:
  - I and S: imm must lie in [-2048, 2047], i.e. imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0] = 0.
  - J: imm[31:20] all equal and imm[0] = 0.
  - U: imm[11:0] = 0.
  - R: imm is ignored.
  - fmt 110 or 111 is always illegal.
- Latency: exactly 1 cycle from transfer to output.
  - Legal bundle: mem_we = 1 for one cycle, with mem_addr = write pointer and mem_wdata = packed word. Write pointer and loaded_cnt then increment.
  - Illegal bundle: mem_we = 0 and err_pulse = 1 for one cycle; err_sticky is set. Pointer and count do not change.
- Back-to-back: one transfer per cycle is sustained; no bubble is required.
- Boundary at the top of memory:
  - A legal write to address DEPTH-1 moves the FSM to FULL; full = 1 and in_ready = 0 from the next cycle.
  - The pointer never wraps to 0.
  - An illegal bundle at DEPTH-1 does not enter FULL.
- FULL:
  - in_ready = 0.
  - load_stop -> IDLE, with full still held at 1.
  - load_start restarts the session.
- Reset mid-operation: a pending write is dropped (mem_we = 0 on the following cycle) and all state returns to reset values.
- Width: loaded_cnt is ADDR_W+1 bits, so a count of DEPTH is representable.

Decomposition:
- Shared package, also used by the immediate generator:
  - Format constants FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_R.
  - RV32I opcode constants.
  - FSM state encodings.
- Natural sub-module: imm_pack. It is purely combinational: fmt, fields and imm in; word and legal flag out.
- The FSM, pointer and output registers stay in the top module.

Test Plan:
- base_addr = 0x10, then I: opcode 0x13, rd 1, rs1 0, funct3 0, imm 5 -> one cycle later mem_we = 1, mem_addr = 0x10, mem_wdata = 0x00500093, loaded_cnt = 1.
- Back-to-back S (sw x2,8(x1)), B (beq x0,x0,imm -4), J (jal x1,imm 2048), U (lui x5,imm 0x12345000), R (add x3,x1,x2) -> consecutive writes at 0x11..0x15 with words 0x0020A423, 0xFE000EE3, 0x001000EF, 0x123452B7, 0x002081B3, and no bubbles.
- Illegal bundles: I with imm 2048, B with imm 3, U with imm 0x12345001 -> each gives err_pulse = 1, mem_we = 0 and err_sticky = 1, with mem_addr and loaded_cnt unchanged. A following legal bundle writes to the unchanged address.
- base_addr = DEPTH-2, two legal bundles -> writes at 254 and 255; full = 1 and in_ready = 0 afterwards. A third in_valid is never accepted; load_start then clears full.
- Assert rst in the cycle after a transfer -> mem_we = 0 on the next cycle, state = IDLE, and all outputs at reset values.
- load_start and in_valid in the same cycle while in LOAD -> the bundle is not written; the pointer reloads to base_addr and loaded_cnt = 0.
